// File: rtl/popcount_pkg.sv
// Shared types and default sizing for the popcount sequencer slice.
package popcount_pkg;

  localparam int DEF_DEPTH   = 16;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_SUM_W   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_RELEASE,
    S_WAIT_LO,
    S_FINISH
  } seq_state_t;

endpackage

// File: rtl/byte_buffer.sv
// DEPTH x 8 byte store: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module byte_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/popcount_sequencer.sv
// Feeds buffered bytes to an external one-counter over a start/done level handshake
// and accumulates total ones, the largest per-byte count and its address.
module popcount_sequencer
  import popcount_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SUM_W   = DEF_SUM_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              go,
  output logic [7:0]        cnt_in,
  output logic              cnt_start,
  input  logic [3:0]        cnt_num,
  input  logic              cnt_done,
  output logic [SUM_W-1:0]  total,
  output logic [3:0]        max_count,
  output logic [ADDR_W-1:0] max_addr,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  seq_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   run_len;
  logic [ADDR_W:0]   len_c;
  logic [ADDR_W:0]   next_cnt;
  logic [WD_W-1:0]   wdog;
  logic [7:0]        rd_data;
  logic              wd_expired;

  byte_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (addr),
    .rd_data (rd_data)
  );

  assign len_c      = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
  assign next_cnt   = {1'b0, addr} + (ADDR_W+1)'(1);
  assign wd_expired = (wdog == WD_W'(TIMEOUT - 1));

  // The watchdog restarts on every state change so each wait phase gets a full TIMEOUT budget.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      run_len   <= '0;
      wdog      <= '0;
      cnt_in    <= '0;
      cnt_start <= 1'b0;
      total     <= '0;
      max_count <= '0;
      max_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      wdog <= wdog + WD_W'(1);
      case (state)
        S_IDLE: begin
          if (go) begin
            total     <= '0;
            max_count <= '0;
            max_addr  <= '0;
            error     <= 1'b0;
            addr      <= '0;
            run_len   <= len_c;
            wdog      <= '0;
            if (len_c == '0) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              busy  <= 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt_in    <= rd_data;
          cnt_start <= 1'b1;
          wdog      <= '0;
          state     <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (cnt_done) begin
            total <= total + SUM_W'(cnt_num);
            if (cnt_num > max_count) begin
              max_count <= cnt_num;
              max_addr  <= addr;
            end
            wdog  <= '0;
            state <= S_RELEASE;
          end else if (wd_expired) begin
            cnt_start <= 1'b0;
            error     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            wdog      <= '0;
            state     <= S_FINISH;
          end
        end
        S_RELEASE: begin
          cnt_start <= 1'b0;
          wdog      <= '0;
          state     <= S_WAIT_LO;
        end
        // A done level left over from the previous byte must clear before the next issue.
        S_WAIT_LO: begin
          if (!cnt_done) begin
            wdog <= '0;
            if (next_cnt == run_len) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              addr  <= next_cnt[ADDR_W-1:0];
              state <= S_ISSUE;
            end
          end else if (wd_expired) begin
            cnt_start <= 1'b0;
            error     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            wdog      <= '0;
            state     <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (!go) begin
            done  <= 1'b0;
            wdog  <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Self-checking bench: sequencer driven against a behavioural one-counter, with a
// scoreboard of expected run results pushed at start and popped at done.
module tb_popcount_sequencer;
  import popcount_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] len;
  logic       go;
  logic [7:0] cnt_in;
  logic       cnt_start;
  logic [3:0] cnt_num;
  logic       cnt_done;
  logic [7:0] total;
  logic [3:0] max_count;
  logic [3:0] max_addr;
  logic       busy;
  logic       done;
  logic       error;

  logic       stub;
  logic       m_done;
  logic [3:0] m_num;
  logic [1:0] m_lat;

  typedef struct {
    int total;
    int maxc;
    int maxa;
    int err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] shadow [DEF_DEPTH];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  popcount_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .len       (len),
    .go        (go),
    .cnt_in    (cnt_in),
    .cnt_start (cnt_start),
    .cnt_num   (cnt_num),
    .cnt_done  (cnt_done),
    .total     (total),
    .max_count (max_count),
    .max_addr  (max_addr),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // One-counter stand-in: answers a start level after a few cycles, drops done once start drops.
  always @(posedge clk) begin
    if (!reset || stub) begin
      m_done <= 1'b0;
      m_num  <= '0;
      m_lat  <= '0;
    end else if (!m_done) begin
      if (cnt_start) begin
        if (m_lat == 2'd2) begin
          m_done <= 1'b1;
          m_num  <= 4'($countones(cnt_in));
          m_lat  <= '0;
        end else begin
          m_lat <= m_lat + 2'd1;
        end
      end else begin
        m_lat <= '0;
      end
    end else if (!cnt_start) begin
      m_done <= 1'b0;
    end
  end

  assign cnt_done = m_done;
  assign cnt_num  = m_num;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t modelRun(input int n);
    exp_t e;
    int   c;
    int   m;
    m = (n > DEF_DEPTH) ? DEF_DEPTH : n;
    e.total = 0;
    e.maxc  = 0;
    e.maxa  = 0;
    e.err   = 0;
    for (int i = 0; i < m; i++) begin
      c = $countones(shadow[i]);
      e.total += c;
      if (c > e.maxc) begin
        e.maxc = c;
        e.maxa = i;
      end
    end
    return e;
  endfunction

  task automatic writeByte(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    shadow[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input int n);
    sb.push_back(modelRun(n));
    len = 5'(n);
    go  = 1'b1;
  endtask

  task automatic waitDone(input string tag, output int cycles);
    cycles = 0;
    while (!done && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) checkOutput({tag, "_hang"}, 0, 1);
  endtask

  task automatic finishRun(input string tag, input bit hold_go, output int cycles);
    exp_t e;
    waitDone(tag, cycles);
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_total"}, int'(total), e.total);
      checkOutput({tag, "_max"},   int'(max_count), e.maxc);
      checkOutput({tag, "_addr"},  int'(max_addr), e.maxa);
      checkOutput({tag, "_error"}, int'(error), e.err);
      checkOutput({tag, "_busy"},  int'(busy), 0);
    end
    if (hold_go) begin
      repeat (5) @(negedge clk);
      checkOutput({tag, "_hold_done"}, int'(done), 1);
    end
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_done_drop"}, int'(done), 0);
  endtask

  initial begin
    int cyc;
    int rises;
    int guard;
    logic prev;
    bit start_seen;

    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    len     = '0;
    go      = 1'b0;
    stub    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",  int'(busy), 0);
    checkOutput("rst_done",  int'(done), 0);
    checkOutput("rst_start", int'(cnt_start), 0);
    checkOutput("rst_total", int'(total), 0);
    checkOutput("rst_error", int'(error), 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic run over four mixed bytes
    writeByte(0, 8'h01);
    writeByte(1, 8'hAA);
    writeByte(2, 8'h00);
    writeByte(3, 8'hFF);
    applyStimulus(4);
    finishRun("t1", 1'b0, cyc);

    // Zero-length run finishes immediately without touching the counter
    applyStimulus(0);
    start_seen = 1'b0;
    @(negedge clk);
    start_seen = start_seen | cnt_start;
    checkOutput("t2_done_next", int'(done), 1);
    finishRun("t2", 1'b0, cyc);
    start_seen = start_seen | cnt_start;
    checkOutput("t2_no_start", int'(start_seen), 0);

    // Equal counts: lowest address wins
    writeByte(0, 8'h0F);
    writeByte(1, 8'hF0);
    writeByte(2, 8'h3C);
    applyStimulus(3);
    finishRun("t3", 1'b0, cyc);

    // Counter never answers: watchdog aborts with partial result
    stub = 1'b1;
    sb.push_back('{total: 0, maxc: 0, maxa: 0, err: 1});
    len = 5'd2;
    go  = 1'b1;
    waitDone("t4", cyc);
    checkOutput("t4_late", int'(cyc >= DEF_TIMEOUT), 1);
    checkOutput("t4_start_low", int'(cnt_start), 0);
    finishRun("t4", 1'b0, cyc);
    stub = 1'b0;
    @(negedge clk);

    // Reset while the third byte is outstanding, then rerun
    writeByte(0, 8'h01);
    writeByte(1, 8'hAA);
    writeByte(2, 8'h00);
    writeByte(3, 8'hFF);
    len   = 5'd4;
    go    = 1'b1;
    rises = 0;
    guard = 0;
    prev  = cnt_start;
    while (rises < 3 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (cnt_start && !prev) rises++;
      prev = cnt_start;
    end
    checkOutput("t5_reached", rises, 3);
    reset = 1'b0;
    go    = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy",  int'(busy), 0);
    checkOutput("t5_start", int'(cnt_start), 0);
    checkOutput("t5_total", int'(total), 0);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(4);
    finishRun("t5", 1'b0, cyc);

    // Full buffer, write attempt while busy, go held in FINISH
    for (int i = 0; i < DEF_DEPTH; i++) writeByte(i, 8'hFF);
    applyStimulus(16);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_busy", int'(busy), 1);
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = 8'h00;
    @(negedge clk);
    wr_en = 1'b0;
    finishRun("t6", 1'b1, cyc);

    // Byte 0 must still hold FF after the ignored write
    applyStimulus(1);
    finishRun("t7", 1'b0, cyc);

    // Oversized length clamps to the buffer depth
    applyStimulus(20);
    finishRun("t8", 1'b0, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
